// File: rtl/pu_msp430_reset_pkg.sv
// Shared types and constants for the MSP430 reset sequencer.
package pu_msp430_reset_pkg;

    // Sequencer phases: power-on hold, power-up-clear hold, normal run
    typedef enum logic [1:0] {
        RST_POR = 2'd0,
        RST_PUC = 2'd1,
        RST_RUN = 2'd2
    } rst_state_e;

    // Bit positions inside rst_cause
    localparam int CAUSE_WDT  = 0;
    localparam int CAUSE_SOFT = 1;
    localparam int CAUSE_DBG  = 2;

    // Larger of two integers, used to size the shared stretch counter
    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pu_msp430_rst_stretch.sv
// Terminal-count stretch counter shared by the POR and PUC hold phases.
// The terminal value is an input so that one counter serves both phases.
module pu_msp430_rst_stretch #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    input  logic [CNT_W-1:0] last,
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    // Counter: clear has priority over increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + CNT_W'(1);
    end

    assign done = (cnt == last);

endmodule

// File: rtl/pu_msp430_reset_ctrl.sv
// MSP430 reset sequencer: produces ordered por / puc_rst from the reset pin
// and the watchdog, software and debug requests, plus a sticky cause register.
module pu_msp430_reset_ctrl
    import pu_msp430_reset_pkg::*;
#(
    parameter int POR_CYCLES = 4,
    parameter int PUC_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wdt_reset,
    input  logic       soft_reset,
    input  logic       dbg_en,
    input  logic       dbg_cpu_reset,
    input  logic       cause_clr,
    output logic       por,
    output logic       puc_rst,
    output logic [2:0] rst_cause,
    output logic       busy
);

    localparam int CNT_W = $clog2(imax(POR_CYCLES, PUC_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] PUC_LAST = CNT_W'(PUC_CYCLES - 1);

    rst_state_e       state_q, state_d;
    logic [1:0]       rst_sync;
    logic             int_rst;
    logic [2:0]       req_vec;
    logic             any_req;
    logic             cnt_clr, cnt_inc, cnt_done;
    logic [CNT_W-1:0] cnt_last, cnt;

    // Reset-pin synchronizer: asserts with reset_n, releases on the 2nd edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rst_sync <= 2'b11;
        else
            rst_sync <= {rst_sync[0], 1'b0};
    end

    assign int_rst = rst_sync[1];

    // Request vector; debug reset only counts while the debug port is enabled
    always_comb begin
        req_vec             = '0;
        req_vec[CAUSE_WDT]  = wdt_reset;
        req_vec[CAUSE_SOFT] = soft_reset;
        req_vec[CAUSE_DBG]  = dbg_en & dbg_cpu_reset;
    end

    assign any_req = |req_vec;

    pu_msp430_rst_stretch #(.CNT_W(CNT_W)) u_stretch (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .last    (cnt_last),
        .cnt     (cnt),
        .done    (cnt_done)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state_q <= RST_POR;
        else
            state_q <= state_d;
    end

    // Next-state and counter control
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        cnt_inc  = 1'b0;
        cnt_last = POR_LAST;
        case (state_q)
            RST_POR: begin
                // Requests do not shorten or extend the power-on hold
                cnt_last = POR_LAST;
                if (int_rst) begin
                    cnt_clr = 1'b1;
                end else if (cnt_done) begin
                    state_d = RST_PUC;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RST_PUC: begin
                // Any live request restarts the hold window
                cnt_last = PUC_LAST;
                if (any_req) begin
                    cnt_clr = 1'b1;
                end else if (cnt_done) begin
                    state_d = RST_RUN;
                    cnt_clr = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            RST_RUN: begin
                cnt_last = PUC_LAST;
                if (any_req) begin
                    state_d = RST_PUC;
                    cnt_clr = 1'b1;
                end
            end
            default: begin
                state_d = RST_POR;
                cnt_clr = 1'b1;
            end
        endcase
    end

    // Registered outputs derived from the next state, so they move on the
    // same edge as the state and never see request inputs combinationally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            por     <= 1'b1;
            puc_rst <= 1'b1;
            busy    <= 1'b1;
        end else begin
            por     <= (state_d == RST_POR);
            puc_rst <= (state_d != RST_RUN);
            busy    <= (state_d != RST_RUN);
        end
    end

    // Sticky cause: new requests win over a same-cycle clear, per bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rst_cause <= 3'b000;
        else
            rst_cause <= (rst_cause & {3{~cause_clr}}) | req_vec;
    end

endmodule
